// File: rtl/tl_source_shrinker.sv
// TileLink UL/UH source shrinker: maps a wide host source space onto
// a small pool of device IDs and restores the host source on D.
module tl_source_shrinker #(
  parameter int HostSourceWidth   = 4,
  parameter int DeviceSourceWidth = 2,
  parameter int SinkWidth         = 1,
  parameter int AddrWidth         = 56,
  parameter int DataWidth         = 64,
  parameter int MaxSize           = 6,
  localparam int NumIds     = 2 ** DeviceSourceWidth,
  localparam int BeatBytes  = DataWidth / 8,
  localparam int OffsetBits = $clog2(BeatBytes),
  localparam int SizeW      = $clog2(MaxSize + 1),
  localparam int BeatW      = (MaxSize > OffsetBits) ?
                              (MaxSize - OffsetBits + 1) : 1,
  localparam int HSW        = HostSourceWidth,
  localparam int DSW        = DeviceSourceWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_host_a_valid,
  output logic                 o_host_a_ready,
  input  logic [2:0]           i_host_a_opcode,
  input  logic [2:0]           i_host_a_param,
  input  logic [SizeW-1:0]     i_host_a_size,
  input  logic [HSW-1:0]       i_host_a_source,
  input  logic [AddrWidth-1:0] i_host_a_address,
  input  logic [BeatBytes-1:0] i_host_a_mask,
  input  logic [DataWidth-1:0] i_host_a_data,
  input  logic                 i_host_a_corrupt,
  output logic                 o_device_a_valid,
  input  logic                 i_device_a_ready,
  output logic [2:0]           o_device_a_opcode,
  output logic [2:0]           o_device_a_param,
  output logic [SizeW-1:0]     o_device_a_size,
  output logic [DSW-1:0]       o_device_a_source,
  output logic [AddrWidth-1:0] o_device_a_address,
  output logic [BeatBytes-1:0] o_device_a_mask,
  output logic [DataWidth-1:0] o_device_a_data,
  output logic                 o_device_a_corrupt,
  input  logic                 i_device_d_valid,
  output logic                 o_device_d_ready,
  input  logic [2:0]           i_device_d_opcode,
  input  logic [1:0]           i_device_d_param,
  input  logic [SizeW-1:0]     i_device_d_size,
  input  logic [DSW-1:0]       i_device_d_source,
  input  logic [SinkWidth-1:0] i_device_d_sink,
  input  logic                 i_device_d_denied,
  input  logic [DataWidth-1:0] i_device_d_data,
  input  logic                 i_device_d_corrupt,
  output logic                 o_host_d_valid,
  input  logic                 i_host_d_ready,
  output logic [2:0]           o_host_d_opcode,
  output logic [1:0]           o_host_d_param,
  output logic [SizeW-1:0]     o_host_d_size,
  output logic [HSW-1:0]       o_host_d_source,
  output logic [SinkWidth-1:0] o_host_d_sink,
  output logic                 o_host_d_denied,
  output logic [DataWidth-1:0] o_host_d_data,
  output logic                 o_host_d_corrupt,
  output logic                 o_host_b_valid,
  input  logic                 i_host_b_ready,
  input  logic                 i_device_b_valid,
  output logic                 o_device_b_ready,
  input  logic                 i_host_c_valid,
  output logic                 o_host_c_ready,
  output logic                 o_device_c_valid,
  input  logic                 i_device_c_ready,
  input  logic                 i_host_e_valid,
  output logic                 o_host_e_ready,
  output logic                 o_device_e_valid,
  input  logic                 i_device_e_ready
);

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] AccessAckData  = 3'd1;

  function automatic logic [BeatW-1:0] f_beats(
    input logic             hasdata,
    input logic [SizeW-1:0] size
  );
    logic [BeatW-1:0] n;
    n = BeatW'(1);
    if (hasdata && size > SizeW'(OffsetBits))
      n = BeatW'(1) << (size - SizeW'(OffsetBits));
    return n;
  endfunction

  logic [NumIds-1:0] r_busy;
  logic [HSW-1:0]    r_src [NumIds];
  logic              r_a_inburst;
  logic [BeatW-1:0]  r_a_left;
  logic [DSW-1:0]    r_a_held_id;
  logic [2:0]        r_a_opc;
  logic [HSW-1:0]    r_a_src;
  logic [BeatW-1:0]  r_d_left;

  logic [DSW-1:0]   w_free_id;
  logic             w_any_free;
  logic             w_a_go;
  logic             w_a_hs;
  logic             w_a_first;
  logic             w_a_hasdata;
  logic [BeatW-1:0] w_a_beats;
  logic             w_d_hs;
  logic             w_d_first;
  logic [BeatW-1:0] w_d_beats;
  logic             w_d_last;
  logic             w_unused;

  always_comb begin
    w_free_id = '0;
    for (int i = NumIds - 1; i >= 0; i--)
      if (!r_busy[i]) w_free_id = DSW'(i);
  end

  assign w_any_free = ~&r_busy;
  // in-burst beats reuse the held ID, so they never wait on a free entry
  assign w_a_go      = r_a_inburst || w_any_free;
  assign w_a_hs      = i_host_a_valid && o_host_a_ready;
  assign w_a_first   = w_a_hs && !r_a_inburst;
  assign w_a_hasdata = i_host_a_opcode inside
    {PutFullData, PutPartialData, ArithmeticData, LogicalData};
  assign w_a_beats   = f_beats(w_a_hasdata, i_host_a_size);

  assign o_device_a_valid   = i_host_a_valid && w_a_go;
  assign o_host_a_ready     = i_device_a_ready && w_a_go;
  assign o_device_a_source  = r_a_inburst ? r_a_held_id : w_free_id;
  assign o_device_a_opcode  = i_host_a_opcode;
  assign o_device_a_param   = i_host_a_param;
  assign o_device_a_size    = i_host_a_size;
  assign o_device_a_address = i_host_a_address;
  assign o_device_a_mask    = i_host_a_mask;
  assign o_device_a_data    = i_host_a_data;
  assign o_device_a_corrupt = i_host_a_corrupt;

  assign w_d_hs    = i_device_d_valid && i_host_d_ready;
  assign w_d_first = (r_d_left == '0);
  assign w_d_beats = f_beats(i_device_d_opcode == AccessAckData,
                             i_device_d_size);
  assign w_d_last  = w_d_first ? (w_d_beats == BeatW'(1))
                               : (r_d_left == BeatW'(1));

  assign o_host_d_valid   = i_device_d_valid;
  assign o_device_d_ready = i_host_d_ready;
  assign o_host_d_source  = r_src[i_device_d_source];
  assign o_host_d_opcode  = i_device_d_opcode;
  assign o_host_d_param   = i_device_d_param;
  assign o_host_d_size    = i_device_d_size;
  assign o_host_d_sink    = i_device_d_sink;
  assign o_host_d_denied  = i_device_d_denied;
  assign o_host_d_data    = i_device_d_data;
  assign o_host_d_corrupt = i_device_d_corrupt;

  assign o_host_b_valid   = 1'b0;
  assign o_device_b_ready = 1'b1;
  assign o_host_c_ready   = 1'b0;
  assign o_device_c_valid = 1'b0;
  assign o_host_e_ready   = 1'b0;
  assign o_device_e_valid = 1'b0;

  assign w_unused = ^{i_host_b_ready, i_device_b_valid, i_device_c_ready,
                      i_device_e_ready, i_host_c_valid, i_host_e_valid};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy      <= '0;
      r_a_inburst <= 1'b0;
      r_a_left    <= '0;
      r_a_held_id <= '0;
      r_a_opc     <= '0;
      r_a_src     <= '0;
      r_d_left    <= '0;
      for (int i = 0; i < NumIds; i++) r_src[i] <= '0;
    end else begin
      if (w_d_hs) begin
        if (w_d_first) r_d_left <= w_d_beats - BeatW'(1);
        else           r_d_left <= r_d_left - BeatW'(1);
        if (w_d_last)  r_busy[i_device_d_source] <= 1'b0;
      end
      // allocation uses the registered busy vector, so it never hits
      // the entry being freed above
      if (w_a_first) begin
        r_busy[w_free_id] <= 1'b1;
        r_src[w_free_id]  <= i_host_a_source;
        r_a_opc           <= i_host_a_opcode;
        r_a_src           <= i_host_a_source;
        if (w_a_beats != BeatW'(1)) begin
          r_a_inburst <= 1'b1;
          r_a_held_id <= w_free_id;
          r_a_left    <= w_a_beats - BeatW'(1);
        end
      end else if (w_a_hs) begin
        r_a_left <= r_a_left - BeatW'(1);
        if (r_a_left == BeatW'(1)) r_a_inburst <= 1'b0;
      end
    end
  end

  ap_d_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    i_device_d_valid |-> r_busy[i_device_d_source]);

  ap_no_ce : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(i_host_c_valid || i_host_e_valid));

  ap_burst_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_a_inburst && i_host_a_valid) |->
    (i_host_a_opcode == r_a_opc && i_host_a_source == r_a_src));

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Scoreboard bench for tl_source_shrinker: directed TL-UL traffic,
// negedge monitor compares device A IDs and restored host D sources.
module tb_tl_source_shrinker;

  localparam int HSW = 4;
  localparam int DSW = 2;
  localparam int AW  = 56;
  localparam int DW  = 64;

  localparam logic [2:0] GET  = 3'd4;
  localparam logic [2:0] PUTF = 3'd0;
  localparam logic [2:0] ACK  = 3'd0;
  localparam logic [2:0] ACKD = 3'd1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          i_host_a_valid;
  logic          o_host_a_ready;
  logic [2:0]    i_host_a_opcode;
  logic [2:0]    i_host_a_param;
  logic [2:0]    i_host_a_size;
  logic [HSW-1:0] i_host_a_source;
  logic [AW-1:0] i_host_a_address;
  logic [7:0]    i_host_a_mask;
  logic [DW-1:0] i_host_a_data;
  logic          i_host_a_corrupt;
  logic          o_device_a_valid;
  logic          i_device_a_ready;
  logic [2:0]    o_device_a_opcode;
  logic [2:0]    o_device_a_param;
  logic [2:0]    o_device_a_size;
  logic [DSW-1:0] o_device_a_source;
  logic [AW-1:0] o_device_a_address;
  logic [7:0]    o_device_a_mask;
  logic [DW-1:0] o_device_a_data;
  logic          o_device_a_corrupt;
  logic          i_device_d_valid;
  logic          o_device_d_ready;
  logic [2:0]    i_device_d_opcode;
  logic [1:0]    i_device_d_param;
  logic [2:0]    i_device_d_size;
  logic [DSW-1:0] i_device_d_source;
  logic [0:0]    i_device_d_sink;
  logic          i_device_d_denied;
  logic [DW-1:0] i_device_d_data;
  logic          i_device_d_corrupt;
  logic          o_host_d_valid;
  logic          i_host_d_ready;
  logic [2:0]    o_host_d_opcode;
  logic [1:0]    o_host_d_param;
  logic [2:0]    o_host_d_size;
  logic [HSW-1:0] o_host_d_source;
  logic [0:0]    o_host_d_sink;
  logic          o_host_d_denied;
  logic [DW-1:0] o_host_d_data;
  logic          o_host_d_corrupt;
  logic          o_host_b_valid;
  logic          i_host_b_ready;
  logic          i_device_b_valid;
  logic          o_device_b_ready;
  logic          i_host_c_valid;
  logic          o_host_c_ready;
  logic          o_device_c_valid;
  logic          i_device_c_ready;
  logic          i_host_e_valid;
  logic          o_host_e_ready;
  logic          o_device_e_valid;
  logic          i_device_e_ready;

  tl_source_shrinker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_host_a_valid(i_host_a_valid), .o_host_a_ready(o_host_a_ready),
    .i_host_a_opcode(i_host_a_opcode), .i_host_a_param(i_host_a_param),
    .i_host_a_size(i_host_a_size), .i_host_a_source(i_host_a_source),
    .i_host_a_address(i_host_a_address), .i_host_a_mask(i_host_a_mask),
    .i_host_a_data(i_host_a_data), .i_host_a_corrupt(i_host_a_corrupt),
    .o_device_a_valid(o_device_a_valid),
    .i_device_a_ready(i_device_a_ready),
    .o_device_a_opcode(o_device_a_opcode),
    .o_device_a_param(o_device_a_param),
    .o_device_a_size(o_device_a_size),
    .o_device_a_source(o_device_a_source),
    .o_device_a_address(o_device_a_address),
    .o_device_a_mask(o_device_a_mask),
    .o_device_a_data(o_device_a_data),
    .o_device_a_corrupt(o_device_a_corrupt),
    .i_device_d_valid(i_device_d_valid),
    .o_device_d_ready(o_device_d_ready),
    .i_device_d_opcode(i_device_d_opcode),
    .i_device_d_param(i_device_d_param),
    .i_device_d_size(i_device_d_size),
    .i_device_d_source(i_device_d_source),
    .i_device_d_sink(i_device_d_sink),
    .i_device_d_denied(i_device_d_denied),
    .i_device_d_data(i_device_d_data),
    .i_device_d_corrupt(i_device_d_corrupt),
    .o_host_d_valid(o_host_d_valid), .i_host_d_ready(i_host_d_ready),
    .o_host_d_opcode(o_host_d_opcode), .o_host_d_param(o_host_d_param),
    .o_host_d_size(o_host_d_size), .o_host_d_source(o_host_d_source),
    .o_host_d_sink(o_host_d_sink), .o_host_d_denied(o_host_d_denied),
    .o_host_d_data(o_host_d_data), .o_host_d_corrupt(o_host_d_corrupt),
    .o_host_b_valid(o_host_b_valid), .i_host_b_ready(i_host_b_ready),
    .i_device_b_valid(i_device_b_valid),
    .o_device_b_ready(o_device_b_ready),
    .i_host_c_valid(i_host_c_valid), .o_host_c_ready(o_host_c_ready),
    .o_device_c_valid(o_device_c_valid),
    .i_device_c_ready(i_device_c_ready),
    .i_host_e_valid(i_host_e_valid), .o_host_e_ready(o_host_e_ready),
    .o_device_e_valid(o_device_e_valid),
    .i_device_e_ready(i_device_e_ready)
  );

  typedef struct packed {
    logic [DSW-1:0] id;
    logic [AW-1:0]  addr;
  } a_exp_t;

  typedef struct packed {
    logic [HSW-1:0] src;
    logic [DW-1:0]  data;
  } d_exp_t;

  a_exp_t aq[$];
  d_exp_t dq[$];
  a_exp_t ea;
  d_exp_t ed;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (o_device_a_valid && i_device_a_ready) begin
        chk("a_pending", 64'(aq.size() > 0), 1);
        if (aq.size() > 0) begin
          ea = aq.pop_front();
          chk("a_source", 64'(o_device_a_source), 64'(ea.id));
          chk("a_address", 64'(o_device_a_address), 64'(ea.addr));
        end
      end
      if (o_host_d_valid && i_host_d_ready) begin
        chk("d_pending", 64'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          ed = dq.pop_front();
          chk("d_source", 64'(o_host_d_source), 64'(ed.src));
          chk("d_data", o_host_d_data, ed.data);
        end
      end
    end
  end

  function automatic int nbeats(input logic hasdata, input logic [2:0] sz);
    return (hasdata && sz > 3'd3) ? (1 << (sz - 3'd3)) : 1;
  endfunction

  task automatic wait_a();
    int n = 0;
    @(negedge clk_i);
    while (!(o_host_a_ready && i_host_a_valid) && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    chk("a_handshake", 64'(n < 40), 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_d();
    int n = 0;
    @(negedge clk_i);
    while (!(o_device_d_ready && i_device_d_valid) && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    chk("d_handshake", 64'(n < 40), 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz,
                         input logic [HSW-1:0] src, input logic [DSW-1:0] id);
    logic [AW-1:0] addr;
    addr = AW'({src, 12'h340});
    aq.push_back({id, addr});
    i_host_a_valid   = 1'b1;
    i_host_a_opcode  = op;
    i_host_a_size    = sz;
    i_host_a_source  = src;
    i_host_a_address = addr;
    i_host_a_mask    = 8'hFF;
    i_host_a_data    = {16{src}};
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [2:0] sz,
                        input logic [HSW-1:0] src, input logic [DSW-1:0] id);
    drive_a(op, sz, src, id);
    wait_a();
    i_host_a_valid = 1'b0;
  endtask

  task automatic a_send(input logic [2:0] op, input logic [2:0] sz,
                        input logic [HSW-1:0] src, input logic [DSW-1:0] id);
    int n;
    n = nbeats(op <= 3'd3, sz);
    for (int i = 0; i < n; i++) a_beat(op, sz, src, id);
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz,
                         input logic [DSW-1:0] dsrc,
                         input logic [HSW-1:0] hsrc, input int beat);
    logic [DW-1:0] data;
    data = 64'hDA7A_0000_0000_0000 | DW'({dsrc, 8'(beat)});
    dq.push_back({hsrc, data});
    i_device_d_valid  = 1'b1;
    i_device_d_opcode = op;
    i_device_d_size   = sz;
    i_device_d_source = dsrc;
    i_device_d_data   = data;
  endtask

  task automatic d_send(input logic [2:0] op, input logic [2:0] sz,
                        input logic [DSW-1:0] dsrc,
                        input logic [HSW-1:0] hsrc);
    int n;
    n = nbeats(op == ACKD, sz);
    for (int i = 0; i < n; i++) begin
      drive_d(op, sz, dsrc, hsrc, i);
      wait_d();
      i_device_d_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    i_host_a_valid = 0; i_host_a_opcode = 0; i_host_a_param = 0;
    i_host_a_size = 0; i_host_a_source = 0; i_host_a_address = 0;
    i_host_a_mask = 0; i_host_a_data = 0; i_host_a_corrupt = 0;
    i_device_a_ready = 0;
    i_device_d_valid = 0; i_device_d_opcode = 0; i_device_d_param = 0;
    i_device_d_size = 0; i_device_d_source = 0; i_device_d_sink = 0;
    i_device_d_denied = 0; i_device_d_data = 0; i_device_d_corrupt = 0;
    i_host_d_ready = 1;
    i_host_b_ready = 1; i_device_b_valid = 0; i_host_c_valid = 0;
    i_device_c_ready = 1; i_host_e_valid = 0; i_device_e_ready = 1;

    repeat (2) @(negedge clk_i);
    chk("rst_dev_a_valid", 64'(o_device_a_valid), 0);
    chk("rst_host_a_ready", 64'(o_host_a_ready), 0);
    chk("rst_host_d_valid", 64'(o_host_d_valid), 0);
    chk("rst_host_b_valid", 64'(o_host_b_valid), 0);
    chk("rst_dev_b_ready", 64'(o_device_b_ready), 1);
    chk("rst_host_c_ready", 64'(o_host_c_ready), 0);
    chk("rst_dev_c_valid", 64'(o_device_c_valid), 0);
    chk("rst_host_e_ready", 64'(o_host_e_ready), 0);
    chk("rst_dev_e_valid", 64'(o_device_e_valid), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    i_device_a_ready = 1'b1;
    @(posedge clk_i); #1;

    // single Get, entry reused right after its response
    a_send(GET, 3'd3, 4'hA, 2'd0);
    d_send(ACKD, 3'd3, 2'd0, 4'hA);
    a_send(GET, 3'd3, 4'h2, 2'd0);
    d_send(ACKD, 3'd3, 2'd0, 4'h2);

    // fill table, stall fifth, same-cycle free of ID 2
    a_send(GET, 3'd3, 4'h1, 2'd0);
    a_send(GET, 3'd3, 4'h5, 2'd1);
    a_send(GET, 3'd3, 4'h9, 2'd2);
    a_send(GET, 3'd3, 4'hF, 2'd3);
    drive_a(GET, 3'd3, 4'h4, 2'd2);
    repeat (3) begin
      @(negedge clk_i);
      chk("full_dev_a_valid", 64'(o_device_a_valid), 0);
      chk("full_host_a_ready", 64'(o_host_a_ready), 0);
    end
    @(posedge clk_i); #1;
    drive_d(ACKD, 3'd3, 2'd2, 4'h9, 0);
    @(negedge clk_i);
    chk("same_cycle_no_alloc", 64'(o_device_a_valid), 0);
    @(posedge clk_i); #1;
    i_device_d_valid = 1'b0;
    wait_a();
    i_host_a_valid = 1'b0;
    d_send(ACKD, 3'd3, 2'd0, 4'h1);
    d_send(ACKD, 3'd3, 2'd3, 4'hF);
    d_send(ACKD, 3'd3, 2'd1, 4'h5);
    d_send(ACKD, 3'd3, 2'd2, 4'h4);

    // 4-beat Put consumes a single entry
    a_send(PUTF, 3'd5, 4'h3, 2'd0);
    a_send(GET, 3'd3, 4'h6, 2'd1);
    d_send(ACK, 3'd5, 2'd0, 4'h3);
    d_send(ACKD, 3'd3, 2'd1, 4'h6);

    // 8-beat response frees its entry only after the last beat
    a_send(GET, 3'd6, 4'h7, 2'd0);
    a_send(GET, 3'd3, 4'h1, 2'd1);
    a_send(GET, 3'd3, 4'h2, 2'd2);
    a_send(GET, 3'd3, 4'h3, 2'd3);
    drive_a(GET, 3'd3, 4'h9, 2'd0);
    for (int b = 0; b < 8; b++) begin
      drive_d(ACKD, 3'd6, 2'd0, 4'h7, b);
      @(negedge clk_i);
      chk("burst_d_blocks_a", 64'(o_device_a_valid), 0);
      @(posedge clk_i); #1;
    end
    i_device_d_valid = 1'b0;
    wait_a();
    i_host_a_valid = 1'b0;
    d_send(ACKD, 3'd3, 2'd0, 4'h9);
    d_send(ACKD, 3'd3, 2'd1, 4'h1);
    d_send(ACKD, 3'd3, 2'd2, 4'h2);
    d_send(ACKD, 3'd3, 2'd3, 4'h3);

    // Put burst keeps going after the table fills up
    a_send(GET, 3'd3, 4'h1, 2'd0);
    a_send(GET, 3'd3, 4'h2, 2'd1);
    a_send(GET, 3'd3, 4'h3, 2'd2);
    a_send(PUTF, 3'd5, 4'h8, 2'd3);
    d_send(ACK, 3'd5, 2'd3, 4'h8);
    d_send(ACKD, 3'd3, 2'd0, 4'h1);
    d_send(ACKD, 3'd3, 2'd1, 4'h2);
    d_send(ACKD, 3'd3, 2'd2, 4'h3);

    // async reset with three entries busy, mid-burst
    a_send(GET, 3'd3, 4'h1, 2'd0);
    a_send(GET, 3'd3, 4'h2, 2'd1);
    a_beat(PUTF, 3'd5, 4'h8, 2'd2);
    a_beat(PUTF, 3'd5, 4'h8, 2'd2);
    #2;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    a_send(GET, 3'd3, 4'hC, 2'd0);
    a_send(GET, 3'd3, 4'hD, 2'd1);
    d_send(ACKD, 3'd3, 2'd0, 4'hC);
    d_send(ACKD, 3'd3, 2'd1, 4'hD);

    repeat (2) @(posedge clk_i);
    chk("a_queue_drained", 64'(aq.size()), 0);
    chk("d_queue_drained", 64'(dq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
